ide_pio_master: RTL and testbench

PIO cycle generator driving the IDE/ATA device bus on behalf of the CPU-side bus logic; the device end of the path whose interrupt line feeds the Gayle interrupt logic. It accepts one register or data-port access request at a time. It sequences the chip selects, register address and DIOR/DIOW strobes with programmable setup/active/hold/recovery times, then returns read data with a one-cycle completion pulse.

---
 rtl/ide_pio_pkg.sv | 43 ++++
 rtl/ide_pio_master_if.sv | 37 +++
 rtl/ide_iordy_sync.sv | 26 ++
 rtl/ide_pio_master.sv | 201 ++++++++++++++++++++
 tb/tb_ide_pio_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ide_pio_pkg.sv
// Shared types, default timing and ADDR field layout for the IDE PIO master.
package ide_pio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACTIVE,
      ST_WAIT,
      ST_HOLD,
      ST_RECOVER
   } state_e;

   localparam int unsigned T_SETUP_DEF       = 2;
   localparam int unsigned T_ACTIVE_DEF      = 6;
   localparam int unsigned T_HOLD_DEF        = 1;
   localparam int unsigned T_RECOVER_DEF     = 4;
   localparam int unsigned IORDY_TIMEOUT_DEF = 255;

   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 16;
   localparam int DA_W       = 3;
   localparam int CS_SEL_BIT = 3;
   localparam int DA_MSB     = 2;
   localparam int DA_LSB     = 0;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Counter preload for a phase lasting t cycles; 0 behaves as 1, long phases saturate.
   function automatic logic [7:0] cnt_load(input int unsigned t);
      if (t <= 1) begin
         return 8'd0;
      end
      if (t > 256) begin
         return 8'hFF;
      end
      return 8'(t - 1);
   endfunction

endpackage

// File: rtl/ide_pio_master_if.sv
// CPU-side request/response signals and IDE device pins of the PIO master.
interface ide_pio_master_if;
   import ide_pio_pkg::*;

   logic              REQ;
   logic              RW;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] RDATA;
   logic              ACK;
   logic              BUSY;
   logic              ERR;
   logic              IDE_CS0_N;
   logic              IDE_CS1_N;
   logic [DA_W-1:0]   IDE_DA;
   logic              IDE_DIOR_N;
   logic              IDE_DIOW_N;
   logic [DATA_W-1:0] IDE_D_OUT;
   logic              IDE_D_OE;
   logic [DATA_W-1:0] IDE_D_IN;
   logic              IORDY;

   modport master (
      input  REQ, RW, ADDR, WDATA, IDE_D_IN, IORDY,
      output RDATA, ACK, BUSY, ERR,
      output IDE_CS0_N, IDE_CS1_N, IDE_DA, IDE_DIOR_N, IDE_DIOW_N,
      output IDE_D_OUT, IDE_D_OE
   );

   modport slave (
      output REQ, RW, ADDR, WDATA, IDE_D_IN, IORDY,
      input  RDATA, ACK, BUSY, ERR,
      input  IDE_CS0_N, IDE_CS1_N, IDE_DA, IDE_DIOR_N, IDE_DIOW_N,
      input  IDE_D_OUT, IDE_D_OE
   );

endinterface

// File: rtl/ide_iordy_sync.sv
// Two-flop synchronizer for the asynchronous IORDY pin; resets to "ready".
module ide_iordy_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/ide_pio_master.sv
// IDE PIO cycle generator: one request at a time, ACK 1+T_SETUP+T_ACTIVE+T_HOLD cycles after accept.
// REQ ignored while BUSY; IORDY wait/timeout only when IDE_IORDY_EN is defined.
module ide_pio_master
   import ide_pio_pkg::*;
#(
   parameter int unsigned T_SETUP   = T_SETUP_DEF,
   parameter int unsigned T_ACTIVE  = T_ACTIVE_DEF,
   parameter int unsigned T_HOLD    = T_HOLD_DEF,
   parameter int unsigned T_RECOVER = T_RECOVER_DEF
`ifdef IDE_IORDY_EN
   ,
   parameter int unsigned IORDY_TIMEOUT = IORDY_TIMEOUT_DEF
`endif
) (
   input logic            CLKCPU,
   input logic            RESET,
   ide_pio_master_if.master io
);

   localparam logic [7:0] LD_SETUP   = cnt_load(T_SETUP);
   localparam logic [7:0] LD_ACTIVE  = cnt_load(T_ACTIVE);
   localparam logic [7:0] LD_HOLD    = cnt_load(T_HOLD);
   localparam logic [7:0] LD_RECOVER = cnt_load(T_RECOVER);
`ifdef IDE_IORDY_EN
   localparam logic [7:0] LD_WAIT    = cnt_load(IORDY_TIMEOUT);
`else
   localparam logic [7:0] LD_WAIT    = 8'd0;
`endif

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic              to_q, to_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              cs0_n_q, cs0_n_d;
   logic              cs1_n_q, cs1_n_d;
   logic [DA_W-1:0]   da_q, da_d;
   logic              dior_n_q, dior_n_d;
   logic              diow_n_q, diow_n_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              doe_q, doe_d;
   logic              iordy_s;
   logic              bus_on;
   logic              strobe_on;

`ifdef IDE_IORDY_EN
   ide_iordy_sync u_iordy_sync (
      .clk (CLKCPU),
      .rst (RESET),
      .d   (io.IORDY),
      .q   (iordy_s)
   );
`else
   logic iordy_unused;
   assign iordy_unused = io.IORDY;
   assign iordy_s      = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      to_d    = to_q;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (io.REQ) begin
               req_d   = '{rw: io.RW, addr: io.ADDR, wdata: io.WDATA};
               to_d    = 1'b0;
               state_d = ST_SETUP;
               cnt_d   = LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_ACTIVE;
               cnt_d   = LD_ACTIVE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_ACTIVE: begin
            if (cnt_q == 8'd0) begin
               if (!iordy_s) begin
                  state_d = ST_WAIT;
                  cnt_d   = LD_WAIT;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = LD_HOLD;
                  if (req_q.rw) begin
                     rdata_d = io.IDE_D_IN;
                  end
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_WAIT: begin
            // A device turning ready on the last allowed cycle is not a timeout.
            if (iordy_s || (cnt_q == 8'd0)) begin
               state_d = ST_HOLD;
               cnt_d   = LD_HOLD;
               to_d    = !iordy_s;
               if (req_q.rw) begin
                  rdata_d = io.IDE_D_IN;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RECOVER;
               cnt_d   = LD_RECOVER;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Pin values are decoded from the next state so every IDE output is a flop.
   always_comb begin
      bus_on    = state_d inside {ST_SETUP, ST_ACTIVE, ST_WAIT, ST_HOLD};
      strobe_on = state_d inside {ST_ACTIVE, ST_WAIT};
      cs0_n_d   = !(bus_on && !req_d.addr[CS_SEL_BIT]);
      cs1_n_d   = !(bus_on &&  req_d.addr[CS_SEL_BIT]);
      da_d      = bus_on ? req_d.addr[DA_MSB:DA_LSB] : '0;
      dior_n_d  = !(strobe_on &&  req_d.rw);
      diow_n_d  = !(strobe_on && !req_d.rw);
      doe_d     = bus_on && !req_d.rw;
      dout_d    = doe_d ? req_d.wdata : dout_q;
      ack_d     = (state_d == ST_RECOVER) && (state_q != ST_RECOVER);
      err_d     = ack_d && to_d;
      busy_d    = state_d != ST_IDLE;
   end

   always_ff @(posedge CLKCPU) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         req_q    <= '0;
         to_q     <= 1'b0;
         rdata_q  <= '0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         cs0_n_q  <= 1'b1;
         cs1_n_q  <= 1'b1;
         da_q     <= '0;
         dior_n_q <= 1'b1;
         diow_n_q <= 1'b1;
         dout_q   <= '0;
         doe_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         to_q     <= to_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         cs0_n_q  <= cs0_n_d;
         cs1_n_q  <= cs1_n_d;
         da_q     <= da_d;
         dior_n_q <= dior_n_d;
         diow_n_q <= diow_n_d;
         dout_q   <= dout_d;
         doe_q    <= doe_d;
      end
   end

   assign io.RDATA      = rdata_q;
   assign io.ACK        = ack_q;
   assign io.BUSY       = busy_q;
   assign io.ERR        = err_q;
   assign io.IDE_CS0_N  = cs0_n_q;
   assign io.IDE_CS1_N  = cs1_n_q;
   assign io.IDE_DA     = da_q;
   assign io.IDE_DIOR_N = dior_n_q;
   assign io.IDE_DIOW_N = diow_n_q;
   assign io.IDE_D_OUT  = dout_q;
   assign io.IDE_D_OE   = doe_q;

endmodule

// File: tb/tb_ide_pio_master.sv
// Self-checking bench for ide_pio_master: directed traces, vector table, and random traffic vs a cycle-offset model.
module tb_ide_pio_master;
   import ide_pio_pkg::*;

   localparam int S   = 2;
   localparam int A   = 6;
   localparam int H   = 1;
   localparam int R   = 4;
   localparam int PER = S + A + H + R + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   ide_pio_master_if bus();

   always #5 clk = ~clk;

   ide_pio_master #(
      .T_SETUP   (S),
      .T_ACTIVE  (A),
      .T_HOLD    (H),
      .T_RECOVER (R)
`ifdef IDE_IORDY_EN
      ,
      .IORDY_TIMEOUT (16)
`endif
   ) dut (
      .CLKCPU (clk),
      .RESET  (rst),
      .io     (bus)
   );

   typedef struct {
      logic        rw;
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [15:0] din;
      logic        cs0_n;
      logic        cs1_n;
      logic [2:0]  da;
      logic [15:0] rdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start(input logic rw, input logic [3:0] a, input logic [15:0] wd);
      bus.REQ   = 1'b1;
      bus.RW    = rw;
      bus.ADDR  = a;
      bus.WDATA = wd;
      @(negedge clk);
      bus.REQ   = 1'b0;
   endtask

   task automatic wait_ack(input int limit, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk);
         if (bus.ACK === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_idle(input int limit);
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < limit && !idle; k++) begin
         @(negedge clk);
         if (bus.BUSY === 1'b0) idle = 1'b1;
      end
      chk("wait_idle", idle, 1'b1);
   endtask

   // Full cycle-by-cycle trace of one access with default timing.
   task automatic trace(input logic rw, input logic [3:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd);
      bit on;
      bit stb;
      start(rw, a, wd);
      for (int c = 1; c <= 14; c++) begin
         on  = (c <= 9);
         stb = (c >= 3) && (c <= 8);
         chk($sformatf("trace c%0d cs0_n", c), bus.IDE_CS0_N, !(on && !a[3]));
         chk($sformatf("trace c%0d cs1_n", c), bus.IDE_CS1_N, !(on && a[3]));
         chk($sformatf("trace c%0d da", c), bus.IDE_DA, on ? a[2:0] : 3'd0);
         chk($sformatf("trace c%0d dior_n", c), bus.IDE_DIOR_N, !(stb && rw));
         chk($sformatf("trace c%0d diow_n", c), bus.IDE_DIOW_N, !(stb && !rw));
         chk($sformatf("trace c%0d d_oe", c), bus.IDE_D_OE, on && !rw);
         if (on && !rw) chk($sformatf("trace c%0d d_out", c), bus.IDE_D_OUT, wd);
         chk($sformatf("trace c%0d ack", c), bus.ACK, c == 10);
         chk($sformatf("trace c%0d busy", c), bus.BUSY, c <= 13);
         if (c == 10) chk("trace rdata", bus.RDATA, exp_rd);
         if (c < 14) @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[5];
      bit          seen;
      int          ack_cyc[$];
      logic [13:0] idle_mask;
      int          acks;
      bit          dior_ok;
      // random-phase model state
      bit          m_busy;
      int          m_o;
      logic        m_rw;
      logic [3:0]  m_addr;
      logic [15:0] m_rd;
      logic [15:0] m_dout;
      logic [42:0] act_v;
      logic [42:0] exp_v;
      bit          bus_on;
      bit          stb;

      vt[0] = '{1'b1, 4'h3, 16'h0000, 16'h1234, 1'b0, 1'b1, 3'd3, 16'h1234};
      vt[1] = '{1'b0, 4'h9, 16'hCAFE, 16'h0000, 1'b1, 1'b0, 3'd1, 16'h1234};
      vt[2] = '{1'b1, 4'hF, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 3'd7, 16'hFFFF};
      vt[3] = '{1'b0, 4'h0, 16'h0001, 16'hAAAA, 1'b0, 1'b1, 3'd0, 16'hFFFF};
      vt[4] = '{1'b1, 4'h8, 16'h0000, 16'h8001, 1'b1, 1'b0, 3'd0, 16'h8001};

      bus.REQ = 1'b0; bus.RW = 1'b0; bus.ADDR = 4'h0; bus.WDATA = 16'h0;
      bus.IDE_D_IN = 16'h0; bus.IORDY = 1'b1;

      // Reset values, then a quiet idle stretch.
      repeat (3) @(negedge clk);
      chk("rst rdata", bus.RDATA, 16'h0);
      chk("rst ack", bus.ACK, 1'b0);
      chk("rst busy", bus.BUSY, 1'b0);
      chk("rst err", bus.ERR, 1'b0);
      chk("rst cs_n", {bus.IDE_CS0_N, bus.IDE_CS1_N}, 2'b11);
      chk("rst da", bus.IDE_DA, 3'd0);
      chk("rst strobes", {bus.IDE_DIOR_N, bus.IDE_DIOW_N}, 2'b11);
      chk("rst d_out", bus.IDE_D_OUT, 16'h0);
      chk("rst d_oe", bus.IDE_D_OE, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle busy/cs", {bus.BUSY, bus.IDE_CS0_N, bus.IDE_CS1_N}, 3'b011);
      end

      // Directed read and write traces.
      bus.IDE_D_IN = 16'h50A1;
      trace(1'b1, 4'h7, 16'h0000, 16'h50A1);
      trace(1'b0, 4'hE, 16'hBEEF, 16'h50A1);

      // REQ held high: accepts at edges 0, 14, 28.
      bus.REQ = 1'b1; bus.RW = 1'b0; bus.ADDR = 4'h1; bus.WDATA = 16'h1111;
      ack_cyc.delete();
      idle_mask = '0;
      for (int c = 1; c <= 42; c++) begin
         @(negedge clk);
         if (bus.ACK === 1'b1) ack_cyc.push_back(c);
         if (c == 14) idle_mask[0] = !bus.BUSY;
         if (c == 28) idle_mask[1] = !bus.BUSY;
         if (c == 42) idle_mask[2] = !bus.BUSY;
         if (c == 15) idle_mask[3] = bus.BUSY;
         if (c == 42) bus.REQ = 1'b0;
      end
      chk("held ack count", ack_cyc.size(), 3);
      if (ack_cyc.size() == 3) begin
         chk("held ack0 cycle", ack_cyc[0], 10);
         chk("held ack1 cycle", ack_cyc[1], 24);
         chk("held ack2 cycle", ack_cyc[2], 38);
      end
      chk("held idle gaps", idle_mask[3:0], 4'hF);

      // Reset in cycle 5 of a read.
      bus.IDE_D_IN = 16'h7777;
      start(1'b1, 4'h7, 16'h0);
      repeat (4) @(negedge clk);
      chk("midrst dior before", bus.IDE_DIOR_N, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst dior_n", bus.IDE_DIOR_N, 1'b1);
      chk("midrst cs0_n", bus.IDE_CS0_N, 1'b1);
      chk("midrst busy", bus.BUSY, 1'b0);
      chk("midrst ack", bus.ACK, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.ACK === 1'b1) acks++;
      end
      chk("midrst no ack", acks, 0);

      // Vector table of single accesses.
      for (int i = 0; i < 5; i++) begin
         bus.IDE_D_IN = vt[i].din;
         start(vt[i].rw, vt[i].addr, vt[i].wdata);
         repeat (4) @(negedge clk);
         chk($sformatf("vec%0d cs0_n", i), bus.IDE_CS0_N, vt[i].cs0_n);
         chk($sformatf("vec%0d cs1_n", i), bus.IDE_CS1_N, vt[i].cs1_n);
         chk($sformatf("vec%0d da", i), bus.IDE_DA, vt[i].da);
         chk($sformatf("vec%0d strobes", i), {bus.IDE_DIOR_N, bus.IDE_DIOW_N},
             {!vt[i].rw, vt[i].rw});
         chk($sformatf("vec%0d d_oe", i), bus.IDE_D_OE, !vt[i].rw);
         wait_ack(20, seen);
         chk($sformatf("vec%0d ack seen", i), seen, 1'b1);
         chk($sformatf("vec%0d rdata", i), bus.RDATA, vt[i].rdata);
         chk($sformatf("vec%0d err", i), bus.ERR, 1'b0);
         wait_idle(20);
      end

`ifdef IDE_IORDY_EN
      // IORDY low for 20 cycles: strobe held through WAIT, data captured on exit.
      bus.IORDY = 1'b0;
      bus.IDE_D_IN = 16'h0BAD;
      start(1'b1, 4'h2, 16'h0);
      dior_ok = 1'b1;
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         if (c == 15) bus.IDE_D_IN = 16'h600D;
         if (c == 20) bus.IORDY = 1'b1;
         if (c >= 3 && c <= 20 && bus.IDE_DIOR_N !== 1'b0) dior_ok = 1'b0;
         if (bus.ACK === 1'b1) seen = 1'b1;
         if (!seen) @(negedge clk);
      end
      chk("iordy dior held", dior_ok, 1'b1);
      chk("iordy ack seen", seen, 1'b1);
      chk("iordy err", bus.ERR, 1'b0);
      chk("iordy rdata", bus.RDATA, 16'h600D);
      wait_idle(20);

      // IORDY stuck low: timeout after 16 WAIT cycles.
      bus.IORDY = 1'b0;
      bus.IDE_D_IN = 16'h3C3C;
      start(1'b1, 4'h5, 16'h0);
      wait_ack(60, seen);
      chk("timeout ack seen", seen, 1'b1);
      chk("timeout err", bus.ERR, 1'b1);
      chk("timeout rdata", bus.RDATA, 16'h3C3C);
      bus.IORDY = 1'b1;
      @(negedge clk);
      chk("timeout err pulse", bus.ERR, 1'b0);
      wait_idle(20);
      repeat (3) @(negedge clk);
`endif

      // Random traffic against a cycle-offset model of the access.
      rst = 1'b1;
      m_busy = 1'b0; m_o = 0; m_rw = 1'b0; m_addr = 4'h0; m_rd = 16'h0; m_dout = 16'h0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 800; i++) begin
         bus_on = m_busy && (m_o <= S + A + H);
         stb    = m_busy && (m_o >= S + 1) && (m_o <= S + A);
         exp_v = {!(bus_on && !m_addr[3]), !(bus_on && m_addr[3]),
                  bus_on ? m_addr[2:0] : 3'd0,
                  !(stb && m_rw), !(stb && !m_rw), bus_on && !m_rw,
                  m_busy && (m_o == S + A + H + 1), m_busy, 1'b0, m_dout, m_rd};
         act_v = {bus.IDE_CS0_N, bus.IDE_CS1_N, bus.IDE_DA, bus.IDE_DIOR_N,
                  bus.IDE_DIOW_N, bus.IDE_D_OE, bus.ACK, bus.BUSY, bus.ERR,
                  bus.IDE_D_OUT, bus.RDATA};
         chk($sformatf("rand step %0d", i), {21'd0, act_v}, {21'd0, exp_v});

         rst          = ($urandom_range(0, 63) == 0);
         bus.REQ      = ($urandom_range(0, 2) == 0);
         bus.RW       = $urandom_range(0, 1) == 1;
         bus.ADDR     = 4'($urandom_range(0, 15));
         bus.WDATA    = 16'($urandom);
         bus.IDE_D_IN = 16'($urandom);

         if (rst) begin
            m_busy = 1'b0; m_o = 0; m_rd = 16'h0; m_dout = 16'h0;
         end else if (m_busy) begin
            m_o++;
            if (m_o == S + A + 1 && m_rw) m_rd = bus.IDE_D_IN;
            if (m_o == PER) begin
               m_busy = 1'b0;
               m_o    = 0;
            end
         end else if (bus.REQ) begin
            m_busy = 1'b1;
            m_o    = 1;
            m_rw   = bus.RW;
            m_addr = bus.ADDR;
            if (!bus.RW) m_dout = bus.WDATA;
         end
         @(negedge clk);
      end
      rst = 1'b0;
      bus.REQ = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
